// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style display responder.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_WAIT  = 2'd3
    } lcd_state_t;

    // Instruction opcodes; the highest set bit selects the instruction.
    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;
    localparam logic [5:0] LINE_LEN   = 6'h28;
    localparam logic [7:0] SPACE      = 8'h20;

    // Address lies inside one of the two 40-column DDRAM lines.
    function automatic logic addr_valid(input logic [6:0] a);
        return (a[5:0] < LINE_LEN);
    endfunction

    // Address lies in the 16 columns held by the frame buffer.
    function automatic logic addr_visible(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next DDRAM address for a single cursor step, including line wrap.
module lcd_addr_step
    import lcd_pkg::*;
(
    input  logic [6:0] addr,
    input  logic       inc,
    output logic [6:0] next_addr
);

    // Step one column; invalid addresses snap to the nearest line start.
    always_comb begin
        next_addr = addr;
        if (!addr_valid(addr)) begin
            next_addr = addr[6] ? LINE1_BASE : LINE2_BASE;
        end else if (inc) begin
            if (addr[5:0] == 6'h27) begin
                next_addr = addr[6] ? LINE1_BASE : LINE2_BASE;
            end else begin
                next_addr = addr + 7'd1;
            end
        end else begin
            if (addr[5:0] == 6'h00) begin
                next_addr = addr[6] ? LINE1_LAST : LINE2_LAST;
            end else begin
                next_addr = addr - 7'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-controller side of the 8-bit HD44780 bus: decodes transfers,
// keeps a 2x16 frame buffer, address counter and busy flag.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT = 960,
    parameter int BUSY_LONG  = 39360
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_E,
    input  logic [7:0] LCD_DB,
    output logic [7:0] LCD_DB_OUT,
    output logic       LCD_DB_OE,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic [6:0] ADDR,
    output logic       BUSY,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       INC_MODE,
    output logic       SHIFT_MODE,
    output logic       FUNC_8BIT,
    output logic       FUNC_2LINE,
    output logic       INIT_DONE,
    output logic       CHAR_STB,
    output logic       CMD_LOST,
    output logic       ERR_STB
);

    // Counter reloads: EXEC and the final zero-count WAIT cycle make up the other two.
    localparam logic [15:0] SHORT_LOAD = 16'(BUSY_SHORT - 2);
    localparam logic [15:0] LONG_LOAD  = 16'(BUSY_LONG - 2);

    logic       e_m_r, e_s_r, e_d_r, rs_m_r, rs_s_r, rs_d_r, rw_m_r, rw_s_r, rw_d_r;
    logic [7:0] db_m_r, db_s_r, db_d_r;
    logic       rise_s, fall_s, step_inc_s;
    logic [6:0] step_addr_s;

    lcd_state_t  state_r, state_n;
    logic [7:0]  cmd_r, cmd_n;
    logic        cmd_rs_r, cmd_rs_n;
    logic [15:0] cnt_r, cnt_n;
    logic [4:0]  clr_idx_r, clr_idx_n;
    logic [6:0]  addr_r, addr_n;
    logic [1:0]  fs_cnt_r, fs_cnt_n;
    logic        disp_r, disp_n, cursor_r, cursor_n, blink_r, blink_n;
    logic        inc_r, inc_n, shift_r, shift_n, dl_r, dl_n, n2_r, n2_n;
    logic        init_r, init_n, char_r, char_n, lost_r, lost_n, err_r, err_n;
    logic        oe_r, oe_n, busy_r;
    logic [7:0]  db_out_r, rd_data_r;
    logic [7:0]  mem_r [32];
    logic        mem_we_s;
    logic [4:0]  mem_idx_s;
    logic [7:0]  mem_wd_s;

    assign rise_s     = e_s_r & ~e_d_r;
    assign fall_s     = e_d_r & ~e_s_r;
    assign step_inc_s = cmd_rs_r ? inc_r : cmd_r[2];

    lcd_addr_step u_step (
        .addr      (addr_r),
        .inc       (step_inc_s),
        .next_addr (step_addr_s)
    );

    // Two-flop synchronizer plus one extra stage for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            {e_m_r, e_s_r, e_d_r}    <= 3'b000;
            {rs_m_r, rs_s_r, rs_d_r} <= 3'b000;
            {rw_m_r, rw_s_r, rw_d_r} <= 3'b000;
            db_m_r <= 8'h00;
            db_s_r <= 8'h00;
            db_d_r <= 8'h00;
        end else begin
            {e_m_r, e_s_r, e_d_r}    <= {LCD_E, e_m_r, e_s_r};
            {rs_m_r, rs_s_r, rs_d_r} <= {LCD_RS, rs_m_r, rs_s_r};
            {rw_m_r, rw_s_r, rw_d_r} <= {LCD_RW, rw_m_r, rw_s_r};
            db_m_r <= LCD_DB;
            db_s_r <= db_m_r;
            db_d_r <= db_s_r;
        end
    end

    // Next-state, instruction effects and strobe decode.
    always_comb begin
        state_n = state_r;   cmd_n = cmd_r;     cmd_rs_n = cmd_rs_r;
        cnt_n = cnt_r;       clr_idx_n = clr_idx_r; addr_n = addr_r;
        fs_cnt_n = fs_cnt_r; disp_n = disp_r;   cursor_n = cursor_r;
        blink_n = blink_r;   inc_n = inc_r;     shift_n = shift_r;
        dl_n = dl_r;         n2_n = n2_r;       init_n = init_r;
        char_n = 1'b0;       lost_n = 1'b0;     err_n = 1'b0;
        oe_n = oe_r;
        mem_we_s = 1'b0;     mem_idx_s = 5'd0;  mem_wd_s = SPACE;

        if (rise_s && rw_s_r && !rs_s_r) begin
            oe_n = 1'b1;
        end else if (fall_s) begin
            oe_n = 1'b0;
        end else begin
            oe_n = oe_r;
        end
        if (fall_s && rw_d_r && rs_d_r) begin
            err_n = 1'b1;
        end else begin
            err_n = 1'b0;
        end
        if (fall_s && !rw_d_r && (state_r != ST_IDLE)) begin
            lost_n = 1'b1;
        end else begin
            lost_n = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_s && !rw_d_r) begin
                    state_n  = ST_EXEC;
                    cmd_n    = db_d_r;
                    cmd_rs_n = rs_d_r;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_n   = ST_WAIT;
                cnt_n     = SHORT_LOAD;
                clr_idx_n = 5'd0;
                if (cmd_rs_r) begin
                    if (addr_visible(addr_r)) begin
                        mem_we_s  = 1'b1;
                        mem_idx_s = {addr_r[6], addr_r[3:0]};
                        mem_wd_s  = cmd_r;
                        char_n    = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    addr_n = step_addr_s;
                end else begin
                    fs_cnt_n = 2'd0;
                    if ((cmd_r & OP_DDRAM) != 8'h00) begin
                        addr_n = cmd_r[6:0];
                        if (!addr_valid(cmd_r[6:0])) begin
                            err_n = 1'b1;
                        end else begin
                            addr_n = cmd_r[6:0];
                        end
                    end else if ((cmd_r & OP_CGRAM) != 8'h00) begin
                        err_n = 1'b1;
                    end else if ((cmd_r & OP_FUNC) != 8'h00) begin
                        dl_n = cmd_r[4];
                        n2_n = cmd_r[3];
                        if (fs_cnt_r == 2'd3) begin
                            fs_cnt_n = 2'd3;
                        end else begin
                            fs_cnt_n = fs_cnt_r + 2'd1;
                        end
                        if (fs_cnt_r >= 2'd2) begin
                            init_n = 1'b1;
                        end else begin
                            init_n = init_r;
                        end
                    end else if ((cmd_r & OP_SHIFT) != 8'h00) begin
                        if (!cmd_r[3]) begin
                            addr_n = step_addr_s;
                        end else begin
                            addr_n = addr_r;
                        end
                    end else if ((cmd_r & OP_DISP) != 8'h00) begin
                        disp_n   = cmd_r[2];
                        cursor_n = cmd_r[1];
                        blink_n  = cmd_r[0];
                    end else if ((cmd_r & OP_ENTRY) != 8'h00) begin
                        inc_n   = cmd_r[1];
                        shift_n = cmd_r[0];
                    end else if ((cmd_r & OP_HOME) != 8'h00) begin
                        addr_n = LINE1_BASE;
                        cnt_n  = LONG_LOAD;
                    end else if ((cmd_r & OP_CLR) != 8'h00) begin
                        state_n = ST_CLEAR;
                        addr_n  = LINE1_BASE;
                        inc_n   = 1'b1;
                        cnt_n   = LONG_LOAD;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we_s  = 1'b1;
                mem_idx_s = clr_idx_r;
                mem_wd_s  = SPACE;
                cnt_n     = cnt_r - 16'd1;
                clr_idx_n = clr_idx_r + 5'd1;
                if (clr_idx_r == 5'd31) begin
                    state_n = ST_WAIT;
                end else begin
                    state_n = ST_CLEAR;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 16'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n   = cnt_r - 16'd1;
                    state_n = ST_WAIT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;  cmd_r <= 8'h00;    cmd_rs_r <= 1'b0;
            cnt_r <= 16'd0;      clr_idx_r <= 5'd0; addr_r <= 7'h00;
            fs_cnt_r <= 2'd0;    disp_r <= 1'b0;    cursor_r <= 1'b0;
            blink_r <= 1'b0;     inc_r <= 1'b1;     shift_r <= 1'b0;
            dl_r <= 1'b1;        n2_r <= 1'b0;      init_r <= 1'b0;
            char_r <= 1'b0;      lost_r <= 1'b0;    err_r <= 1'b0;
            oe_r <= 1'b0;        busy_r <= 1'b0;    db_out_r <= 8'h00;
        end else begin
            state_r <= state_n;  cmd_r <= cmd_n;    cmd_rs_r <= cmd_rs_n;
            cnt_r <= cnt_n;      clr_idx_r <= clr_idx_n; addr_r <= addr_n;
            fs_cnt_r <= fs_cnt_n; disp_r <= disp_n; cursor_r <= cursor_n;
            blink_r <= blink_n;  inc_r <= inc_n;    shift_r <= shift_n;
            dl_r <= dl_n;        n2_r <= n2_n;      init_r <= init_n;
            char_r <= char_n;    lost_r <= lost_n;  err_r <= err_n;
            oe_r <= oe_n;
            busy_r <= (state_n != ST_IDLE);
            db_out_r <= oe_n ? {(state_n != ST_IDLE), addr_n} : 8'h00;
        end
    end

    // Frame buffer; reset fills it with spaces so an aborted clear leaves no residue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= SPACE;
            end
        end else if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wd_s;
        end else begin
            mem_r[mem_idx_s] <= mem_r[mem_idx_s];
        end
    end

    // Synchronous buffer read port; a same-cycle write is not forwarded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_r <= 8'h00;
        end else begin
            rd_data_r <= mem_r[RD_ADDR];
        end
    end

    assign LCD_DB_OUT = db_out_r;
    assign LCD_DB_OE  = oe_r;
    assign RD_DATA    = rd_data_r;
    assign ADDR       = addr_r;
    assign BUSY       = busy_r;
    assign DISP_ON    = disp_r;
    assign CURSOR_ON  = cursor_r;
    assign BLINK_ON   = blink_r;
    assign INC_MODE   = inc_r;
    assign SHIFT_MODE = shift_r;
    assign FUNC_8BIT  = dl_r;
    assign FUNC_2LINE = n2_r;
    assign INIT_DONE  = init_r;
    assign CHAR_STB   = char_r;
    assign CMD_LOST   = lost_r;
    assign ERR_STB    = err_r;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed self-checking bench for the HD44780 bus responder.
module tb_lcd_hd44780_responder;

    logic       clk = 1'b0, rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_db = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] lcd_db_out, rd_data;
    logic       lcd_db_oe, busy, disp_on, cursor_on, blink_on, inc_mode, shift_mode;
    logic       func_8bit, func_2line, init_done, char_stb, cmd_lost, err_stb;
    logic [6:0] addr;

    logic [6:0] st_addr = 7'h00;
    logic       st_inc = 1'b0;
    logic [6:0] st_next;

    int chk_cnt = 0, pass_cnt = 0;
    int char_cnt = 0, lost_cnt = 0, err_cnt = 0;

    lcd_hd44780_responder #(.BUSY_SHORT(120), .BUSY_LONG(39360)) dut (
        .CLK(clk), .RST(rst), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e),
        .LCD_DB(lcd_db), .LCD_DB_OUT(lcd_db_out), .LCD_DB_OE(lcd_db_oe),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .ADDR(addr), .BUSY(busy),
        .DISP_ON(disp_on), .CURSOR_ON(cursor_on), .BLINK_ON(blink_on),
        .INC_MODE(inc_mode), .SHIFT_MODE(shift_mode), .FUNC_8BIT(func_8bit),
        .FUNC_2LINE(func_2line), .INIT_DONE(init_done), .CHAR_STB(char_stb),
        .CMD_LOST(cmd_lost), .ERR_STB(err_stb)
    );

    lcd_addr_step u_step (.addr(st_addr), .inc(st_inc), .next_addr(st_next));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (char_stb) char_cnt++;
        if (cmd_lost) lost_cnt++;
        if (err_stb)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lcd_strobe(input logic rs, input logic rw, input logic [7:0] db);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_db = db;
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy && n < 45000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 45000) check("busy_timeout", busy, 1'b0);
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] db);
        lcd_strobe(rs, 1'b0, db);
        wait_idle();
    endtask

    task automatic read_buf(input logic [4:0] idx, output logic [7:0] d);
        @(negedge clk);
        rd_addr = idx;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_all_space(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 32; i++) begin
            read_buf(5'(i), d);
            check($sformatf("%s[%0d]", tag, i), d, 8'h20);
        end
    endtask

    task automatic step_chk(input logic [6:0] a, input logic i, input logic [6:0] e);
        st_addr = a; st_inc = i;
        #1;
        check($sformatf("step_%0h_%0d", a, i), st_next, e);
    endtask

    initial begin
        logic [7:0] d;
        int n, k, c0, e0;

        // Standalone address-step vectors
        step_chk(7'h27, 1'b1, 7'h40);
        step_chk(7'h67, 1'b1, 7'h00);
        step_chk(7'h00, 1'b0, 7'h67);
        step_chk(7'h40, 1'b0, 7'h27);
        step_chk(7'h05, 1'b1, 7'h06);
        step_chk(7'h45, 1'b0, 7'h44);
        step_chk(7'h30, 1'b1, 7'h40);
        step_chk(7'h70, 1'b0, 7'h00);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 7'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_inc", inc_mode, 1'b1);
        check("rst_dl", func_8bit, 1'b1);
        check("rst_n", func_2line, 1'b0);
        check("rst_init", init_done, 1'b0);
        check("rst_oe", lcd_db_oe, 1'b0);
        check("rst_rd", rd_data, 8'h00);
        rst = 1'b0;

        // 1: init sequence, display setup, clear timing
        lcd_write(1'b0, 8'h38);
        lcd_write(1'b0, 8'h38);
        check("init_after2", init_done, 1'b0);
        lcd_write(1'b0, 8'h38);
        check("init_done", init_done, 1'b1);
        check("func_8bit", func_8bit, 1'b1);
        check("func_2line", func_2line, 1'b1);
        lcd_write(1'b0, 8'h38);
        lcd_write(1'b0, 8'h08);
        check("disp_off", disp_on, 1'b0);
        lcd_strobe(1'b0, 1'b0, 8'h01);
        n = 0; k = 0;
        while (k < 50000 && !(n > 0 && !busy)) begin
            @(negedge clk);
            if (busy) n++;
            k++;
        end
        check("clr_busy_len", n, 39360);
        lcd_write(1'b0, 8'h0C);
        lcd_write(1'b0, 8'h06);
        check("disp_on", disp_on, 1'b1);
        check("cursor_on", cursor_on, 1'b0);
        check("blink_on", blink_on, 1'b0);
        check("inc_mode", inc_mode, 1'b1);
        check_all_space("clr1");

        // 2: two characters on line 1
        c0 = char_cnt;
        lcd_write(1'b1, 8'h57);
        lcd_write(1'b1, 8'h45);
        read_buf(5'd0, d); check("buf0", d, 8'h57);
        read_buf(5'd1, d); check("buf1", d, 8'h45);
        check("addr_02", addr, 7'h02);
        check("char_cnt2", char_cnt - c0, 2);

        // 3: last visible column, off-screen column, line 2 start; 4-cycle latency
        c0 = char_cnt;
        lcd_strobe(1'b0, 1'b0, 8'h8F);
        repeat (3) @(negedge clk);
        check("lat_before", addr, 7'h02);
        @(negedge clk);
        check("lat_after", addr, 7'h0F);
        wait_idle();
        lcd_write(1'b1, 8'h41);
        lcd_write(1'b1, 8'h42);
        read_buf(5'd15, d); check("buf15", d, 8'h41);
        read_buf(5'd16, d); check("buf16_keep", d, 8'h20);
        check("addr_11", addr, 7'h11);
        check("char_cnt1", char_cnt - c0, 1);
        lcd_write(1'b0, 8'hC0);
        lcd_write(1'b1, 8'h4C);
        read_buf(5'd16, d); check("buf16", d, 8'h4C);

        // 4: line-2 end wrap, decrement wrap, invalid address
        lcd_write(1'b0, 8'hE7);
        lcd_write(1'b1, 8'h20);
        check("wrap_67_00", addr, 7'h00);
        lcd_write(1'b0, 8'h04);
        check("inc_off", inc_mode, 1'b0);
        lcd_write(1'b0, 8'h80);
        lcd_write(1'b1, 8'h58);
        read_buf(5'd0, d); check("buf0_x", d, 8'h58);
        check("wrap_00_67", addr, 7'h67);
        e0 = err_cnt;
        lcd_write(1'b0, 8'hA8);
        check("bad_addr_kept", addr, 7'h28);
        check("bad_addr_err", err_cnt - e0, 1);
        lcd_write(1'b0, 8'h14);
        check("bad_addr_snap", addr, 7'h40);
        lcd_write(1'b0, 8'h10);
        check("wrap_40_27", addr, 7'h27);

        // 5: lost command and status read during clear
        k = lost_cnt; e0 = err_cnt;
        lcd_strobe(1'b0, 1'b0, 8'h01);
        repeat (100) @(negedge clk);
        lcd_strobe(1'b0, 1'b0, 8'h08);
        repeat (4) @(negedge clk);
        check("cmd_lost", lost_cnt - k, 1);
        lcd_strobe(1'b0, 1'b1, 8'h00);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_oe", lcd_db_oe, 1'b1);
        check("rd_out", lcd_db_out, 8'h80);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_oe_off", lcd_db_oe, 1'b0);
        check("rd_no_err", err_cnt - e0, 0);
        lcd_strobe(1'b1, 1'b1, 8'h00);
        repeat (4) @(negedge clk);
        check("data_rd_err", err_cnt - e0, 1);
        check("data_rd_oe", lcd_db_oe, 1'b0);
        wait_idle();
        check("lost_ignored", disp_on, 1'b1);
        check("clr_inc", inc_mode, 1'b1);
        check("clr_addr", addr, 7'h00);
        read_buf(5'd0, d); check("clr_buf0", d, 8'h20);

        // 6: reset mid-clear, then unsupported CGRAM address
        lcd_write(1'b0, 8'hC4);
        lcd_write(1'b1, 8'h5A);
        read_buf(5'd20, d); check("buf20", d, 8'h5A);
        lcd_strobe(1'b0, 1'b0, 8'h01);
        repeat (16) @(negedge clk);
        check("mid_clr_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clr_busy", busy, 1'b0);
        check("rst_clr_addr", addr, 7'h00);
        rst = 1'b0;
        check_all_space("rst_clr");
        e0 = err_cnt;
        lcd_write(1'b0, 8'h48);
        check("cgram_err", err_cnt - e0, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
